led_matrix_scan_ctrl: RTL and testbench
=======================================

Name: led_matrix_scan_ctrl

Overview:
Row-scanning driver for an 8x8 bicolour (red/green) LED matrix. Each row's pixel codes are fetched from a 64-entry frame memory over a request/valid handshake, one row ahead into a shadow buffer. The active row is driven onto one-hot row and column lines, with screen, point and colour flicker overlays. It sits between the frame memory (SPI memory or emulator) and the LED pins.

Parameters:
LED_ACTIVE_LEVEL, 1, logic level meaning "LED on" for led_row/led_col_*; 0 inverts all three LED buses.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
en  in  1  scanner enable
scan_tick  in  1  one-clk pulse, advance to next row
flicker_phase  in  1  flicker level, 1 = on phase, 0 = off phase
screen_flicker_en  in  1  blank whole screen during off phase
point_flicker_en  in  1  enable single-pixel flicker
point_flicker_pos  in  6  {row[2:0], col[2:0]} of flicker pixel
point_flicker_color  in  1  0 = red, 1 = green
color_flicker_en  in  1  blank one colour during off phase
color_flicker_color  in  1  colour blanked, 0 = red, 1 = green
mem_busy  in  1  memory cannot accept a request
mem_en  out  1  one-cycle read request
mem_valid  in  1  one-cycle read-data-valid pulse
mem_addr  out  6  row*8+col
mem_data  in  2  pixel code {red, green}: 00 off, 10 red, 01 green, 11 both
led_row  out  8  one-hot active row, bit i = row i
led_col_red  out  8  red column drive, bit c = column c
led_col_green  out  8  green column drive

Behaviour:
- Reset: cur_row=7, fetch_row=0, display and shadow buffers all 00, mem_en=0, mem_addr=0, FSM IDLE, LED outputs all "off" (~LED_ACTIVE_LEVEL).
- Fetch FSM: IDLE -> REQ when en=1 and shadow row not yet fetched. Shadow is cleared to 00 on entry.
  - REQ: when mem_busy=0, pulse mem_en for 1 clk with mem_addr={fetch_row,col} -> WAIT.
  - WAIT: on mem_valid, store mem_data in shadow[col]. col<7: col+1 -> REQ. col=7: -> DONE.
  - mem_valid outside WAIT is ignored. mem_en is never asserted while mem_busy=1.
- On scan_tick with en=1 (any FSM state):
  - cur_row <= fetch_row; display <= shadow. Unfetched columns show off.
  - fetch_row <= fetch_row+1 (wraps 7->0); col <= 0; FSM -> REQ.
  - An outstanding request is abandoned; a late mem_valid is ignored.
- Row data appears on the tick after its fetch. Rows are scanned in order 0..7 and wrap.
- en=0: LED outputs off, mem_en=0, FSM IDLE, cur_row=7, fetch_row=0. Re-enabling restarts from row 0 fetch.
- Pixel composition, combinational from display, cur_row and overlay inputs:
  - base red/green = display[c] bits.
  - color_flicker_en and flicker_phase=0: bits of color_flicker_color forced 0.
  - point_flicker_en and point_flicker_pos row = cur_row, col = c: overrides base. On phase: only the point_flicker_color bit is 1. Off phase: both 0.
  - screen_flicker_en and flicker_phase=0: all columns off (highest priority).
- led_row = one-hot(cur_row) when en=1.
- Active-high polarity for all three buses when LED_ACTIVE_LEVEL=1; all three inverted when 0.
- Outputs registered-free apart from state; no glitch requirement beyond synchronous state.

Optional Feature:
LED_SCAN_BLANKING_EN
- Defined: after each scan_tick-driven row change, all LED outputs are forced off for exactly 1 clk (anti-ghosting); rows resume on the next cycle.
- Undefined: the new row is driven in the cycle immediately after the tick.

Test Plan:
- Fill memory with row 0 = {_,G,R,R,G,G,R,_} (col 0..7), row 5 = {R,R,G,G,R,R,G,G}, others 00; release reset, en=1, issue ticks.
  - When led_row=8'h01: led_col_red=8'b0100_1100 and led_col_green=8'b0011_0010 (bit c = col c).
  - Row 5: red=8'b0011_0011, green=8'b1100_1100.
- Empty memory, point_flicker_en=1, pos={2,2}, colour red.
  - Row 2 on phase: red=8'h04, green=0.
  - Off phase: all 0.
  - Other rows: 0.
- Same with pos={0,7} green: row 0 on phase, green=8'h80. Pos={7,7} red: row 7, red=8'h80.
- mem_busy held 1 for 20 clks mid-fetch: mem_en stays 0, then resumes; all 8 addresses row*8+0..7 issued exactly once per row.
- screen_flicker_en=1, flicker_phase=0: all col outputs 0 regardless of memory. Assert rst mid-fetch: outputs off immediately, mem_en=0.
- Tick before fetch completes (mem_valid delayed): row shows only fetched columns, rest off; next row fetch begins at col 0.

Source files
------------

// File: rtl/led_matrix_scan_ctrl.sv
// Row scanner for an 8x8 red/green LED matrix: fetches the next row into a shadow buffer while the current row is displayed.
// Optional macro LED_SCAN_BLANKING_EN blanks all LED outputs for one clk after every tick-driven row change.
module led_matrix_scan_ctrl #(
    parameter logic LED_ACTIVE_LEVEL = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       scan_tick,
    input  logic       flicker_phase,
    input  logic       screen_flicker_en,
    input  logic       point_flicker_en,
    input  logic [5:0] point_flicker_pos,
    input  logic       point_flicker_color,
    input  logic       color_flicker_en,
    input  logic       color_flicker_color,
    input  logic       mem_busy,
    output logic       mem_en,
    input  logic       mem_valid,
    output logic [5:0] mem_addr,
    input  logic [1:0] mem_data,
    output logic [7:0] led_row,
    output logic [7:0] led_col_red,
    output logic [7:0] led_col_green
);

    localparam int COLS = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } fetch_state_t;

    fetch_state_t state_r;
    fetch_state_t state_s;

    logic [2:0] cur_row_r;
    logic [2:0] fetch_row_r;
    logic [2:0] col_r;
    logic [1:0] display_r [COLS];
    logic [1:0] shadow_r  [COLS];

    logic       blank_s;
    logic       drive_s;
    logic       scr_blank_s;
    logic       cf_red_off_s;
    logic       cf_green_off_s;
    logic [7:0] pt_hit_s;
    logic [7:0] row_s;
    logic [7:0] red_s;
    logic [7:0] green_s;

    // A tick in the same cycle suppresses the request, since that fetch would be abandoned anyway.
    assign mem_en   = (state_r == ST_REQ) & ~mem_busy & en & ~scan_tick;
    assign mem_addr = {fetch_row_r, col_r};

    // Fetch FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Fetch FSM next-state logic; disable and tick override the handshake progress.
    always_comb begin
        state_s = state_r;
        if (!en) begin
            state_s = ST_IDLE;
        end else if (scan_tick) begin
            state_s = ST_REQ;
        end else begin
            case (state_r)
                ST_IDLE: state_s = ST_REQ;
                ST_REQ: begin
                    if (!mem_busy) state_s = ST_WAIT;
                    else           state_s = ST_REQ;
                end
                ST_WAIT: begin
                    if (mem_valid) begin
                        if (col_r == 3'd7) state_s = ST_DONE;
                        else               state_s = ST_REQ;
                    end else begin
                        state_s = ST_WAIT;
                    end
                end
                ST_DONE: state_s = ST_DONE;
                default: state_s = ST_IDLE;
            endcase
        end
    end

    // Row pointers, column counter, shadow fill and shadow-to-display swap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_row_r   <= 3'd7;
            fetch_row_r <= 3'd0;
            col_r       <= 3'd0;
            for (int i = 0; i < COLS; i++) begin
                display_r[i] <= 2'b00;
                shadow_r[i]  <= 2'b00;
            end
        end else if (!en) begin
            cur_row_r   <= 3'd7;
            fetch_row_r <= 3'd0;
            col_r       <= 3'd0;
            for (int i = 0; i < COLS; i++) begin
                display_r[i] <= 2'b00;
                shadow_r[i]  <= 2'b00;
            end
        end else if (scan_tick) begin
            // Columns not yet fetched were cleared, so they display as off.
            cur_row_r   <= fetch_row_r;
            fetch_row_r <= fetch_row_r + 3'd1;
            col_r       <= 3'd0;
            for (int i = 0; i < COLS; i++) begin
                display_r[i] <= shadow_r[i];
                shadow_r[i]  <= 2'b00;
            end
        end else if (state_r == ST_IDLE) begin
            col_r <= 3'd0;
            for (int i = 0; i < COLS; i++) begin
                shadow_r[i] <= 2'b00;
            end
        end else if ((state_r == ST_WAIT) && mem_valid) begin
            shadow_r[col_r] <= mem_data;
            if (col_r != 3'd7) begin
                col_r <= col_r + 3'd1;
            end else begin
                col_r <= col_r;
            end
        end else begin
            col_r <= col_r;
        end
    end

`ifdef LED_SCAN_BLANKING_EN
    logic blank_r;

    // One-clk anti-ghosting blank following each row change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blank_r <= 1'b0;
        end else begin
            blank_r <= en & scan_tick;
        end
    end

    assign blank_s = blank_r;
`else
    assign blank_s = 1'b0;
`endif

    assign drive_s        = en & ~rst & ~blank_s;
    assign scr_blank_s    = screen_flicker_en & ~flicker_phase;
    assign cf_red_off_s   = color_flicker_en & ~flicker_phase & ~color_flicker_color;
    assign cf_green_off_s = color_flicker_en & ~flicker_phase &  color_flicker_color;

    // Pixel composition: screen blank beats point flicker, which beats colour-masked base data.
    always_comb begin
        row_s    = 8'h00;
        red_s    = 8'h00;
        green_s  = 8'h00;
        pt_hit_s = 8'h00;
        if (drive_s) begin
            row_s[cur_row_r] = 1'b1;
            for (int c = 0; c < COLS; c++) begin
                pt_hit_s[c] = point_flicker_en & (point_flicker_pos == {cur_row_r, 3'(c)});
                red_s[c]    = scr_blank_s ? 1'b0 :
                              (pt_hit_s[c] ? (flicker_phase & ~point_flicker_color)
                                           : (display_r[c][1] & ~cf_red_off_s));
                green_s[c]  = scr_blank_s ? 1'b0 :
                              (pt_hit_s[c] ? (flicker_phase & point_flicker_color)
                                           : (display_r[c][0] & ~cf_green_off_s));
            end
        end else begin
            row_s   = 8'h00;
            red_s   = 8'h00;
            green_s = 8'h00;
        end
    end

    assign led_row       = (LED_ACTIVE_LEVEL == 1'b1) ? row_s   : ~row_s;
    assign led_col_red   = (LED_ACTIVE_LEVEL == 1'b1) ? red_s   : ~red_s;
    assign led_col_green = (LED_ACTIVE_LEVEL == 1'b1) ? green_s : ~green_s;

endmodule

// File: tb/tb_led_matrix_scan_ctrl.sv
// Directed bench for led_matrix_scan_ctrl with a frame-memory model and an address scoreboard.
module tb_led_matrix_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       scan_tick;
    logic       flicker_phase;
    logic       screen_flicker_en;
    logic       point_flicker_en;
    logic [5:0] point_flicker_pos;
    logic       point_flicker_color;
    logic       color_flicker_en;
    logic       color_flicker_color;
    logic       mem_busy;
    logic       mem_en;
    logic       mem_valid;
    logic [5:0] mem_addr;
    logic [1:0] mem_data;
    logic [7:0] led_row;
    logic [7:0] led_col_red;
    logic [7:0] led_col_green;

    int         total = 0;
    int         bad = 0;
    int         lat = 1;
    int         pend_cnt;
    logic [5:0] pend_addr;
    logic [1:0] mem [64];
    logic [5:0] exp_addr_q [$];
    int         exp_fetch_row;
    logic [7:0] one_hot;

    led_matrix_scan_ctrl dut (
        .clk                 (clk),
        .rst                 (rst),
        .en                  (en),
        .scan_tick           (scan_tick),
        .flicker_phase       (flicker_phase),
        .screen_flicker_en   (screen_flicker_en),
        .point_flicker_en    (point_flicker_en),
        .point_flicker_pos   (point_flicker_pos),
        .point_flicker_color (point_flicker_color),
        .color_flicker_en    (color_flicker_en),
        .color_flicker_color (color_flicker_color),
        .mem_busy            (mem_busy),
        .mem_en              (mem_en),
        .mem_valid           (mem_valid),
        .mem_addr            (mem_addr),
        .mem_data            (mem_data),
        .led_row             (led_row),
        .led_col_red         (led_col_red),
        .led_col_green       (led_col_green)
    );

    always #5 clk = ~clk;

    // Memory model (single outstanding read) plus request monitor against the address scoreboard.
    initial begin
        logic [5:0] e;
        mem_valid = 1'b0;
        mem_data  = 2'b00;
        pend_cnt  = 0;
        pend_addr = 6'd0;
        forever begin
            @(posedge clk);
            #1;
            mem_valid = 1'b0;
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    mem_valid = 1'b1;
                    mem_data  = mem[pend_addr];
                end
            end
            @(negedge clk);
            if (mem_en === 1'b1) begin
                total++;
                assert (mem_busy === 1'b0) else begin
                    bad++;
                    $error("FAIL req_while_busy observed=%b expected=0", mem_busy);
                end
                total++;
                assert (exp_addr_q.size() > 0) else begin
                    bad++;
                    $error("FAIL addr_unexpected observed=%0d expected=none", mem_addr);
                end
                if (exp_addr_q.size() > 0) begin
                    e = exp_addr_q.pop_front();
                    total++;
                    assert (mem_addr === e) else begin
                        bad++;
                        $error("FAIL addr_order observed=%0d expected=%0d", mem_addr, e);
                    end
                end
                pend_addr = mem_addr;
                pend_cnt  = lat;
            end
        end
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_row(input int r);
        for (int c = 0; c < 8; c++) exp_addr_q.push_back(6'(r * 8 + c));
    endtask

    task automatic en_on();
        @(posedge clk);
        #1 en = 1'b1;
        exp_fetch_row = 0;
        push_row(0);
    endtask

    task automatic en_off();
        @(posedge clk);
        #1 en = 1'b0;
        exp_addr_q.delete();
        repeat (4) @(posedge clk);
    endtask

    task automatic do_tick(input int wait_cyc, input bit expect_done);
        repeat (wait_cyc) @(posedge clk);
        if (expect_done) begin
            total++;
            assert (exp_addr_q.size() == 0) else begin
                bad++;
                $error("FAIL fetch_incomplete observed=%0d expected=0", exp_addr_q.size());
            end
        end else begin
            exp_addr_q.delete();
        end
        #1 scan_tick = 1'b1;
        push_row((exp_fetch_row + 1) % 8);
        @(posedge clk);
        #1 scan_tick = 1'b0;
        exp_fetch_row = (exp_fetch_row + 1) % 8;
`ifdef LED_SCAN_BLANKING_EN
        @(negedge clk);
        chk("blank_row", led_row, 8'h00);
        @(posedge clk);
`endif
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; scan_tick = 1'b0; flicker_phase = 1'b1;
        screen_flicker_en = 1'b0; point_flicker_en = 1'b0; point_flicker_pos = 6'd0;
        point_flicker_color = 1'b0; color_flicker_en = 1'b0; color_flicker_color = 1'b0;
        mem_busy = 1'b0; exp_fetch_row = 0;
        for (int i = 0; i < 64; i++) mem[i] = 2'b00;
        // row 0 = {_,G,R,R,G,G,R,_}, row 5 = {R,R,G,G,R,R,G,G}
        mem[1] = 2'b01; mem[2] = 2'b10; mem[3] = 2'b10; mem[4] = 2'b01;
        mem[5] = 2'b01; mem[6] = 2'b10;
        mem[40] = 2'b10; mem[41] = 2'b10; mem[42] = 2'b01; mem[43] = 2'b01;
        mem[44] = 2'b10; mem[45] = 2'b10; mem[46] = 2'b01; mem[47] = 2'b01;

        repeat (3) @(negedge clk);
        chk("rst_row", led_row, 8'h00);
        chk("rst_red", led_col_red, 8'h00);
        chk("rst_green", led_col_green, 8'h00);
        chk("rst_mem_en", {7'd0, mem_en}, 8'h00);
        chk("rst_mem_addr", {2'd0, mem_addr}, 8'h00);

        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        en_on();
        @(negedge clk);
        chk("enable_row7", led_row, 8'h80);

        do_tick(30, 1'b1);
        chk("r0_row", led_row, 8'h01);
        chk("r0_red", led_col_red, 8'b0100_1100);
        chk("r0_green", led_col_green, 8'b0011_0010);
        for (int r = 1; r <= 5; r++) begin
            do_tick(30, 1'b1);
            one_hot = 8'h01 << r;
            chk("scan_row", led_row, one_hot);
        end
        chk("r5_red", led_col_red, 8'b0011_0011);
        chk("r5_green", led_col_green, 8'b1100_1100);
        do_tick(30, 1'b1);
        do_tick(30, 1'b1);
        do_tick(30, 1'b1);
        chk("wrap_row", led_row, 8'h01);
        chk("wrap_red", led_col_red, 8'b0100_1100);

        // Point flicker over an empty memory.
        en_off();
        chk("dis_row", led_row, 8'h00);
        for (int i = 0; i < 64; i++) mem[i] = 2'b00;
        en_on();
        point_flicker_en = 1'b1; point_flicker_pos = 6'b010_010; point_flicker_color = 1'b0;
        do_tick(30, 1'b1);
        chk("pf_other_red", led_col_red, 8'h00);
        do_tick(30, 1'b1);
        do_tick(30, 1'b1);
        chk("pf22_row", led_row, 8'h04);
        chk("pf22_red", led_col_red, 8'h04);
        chk("pf22_green", led_col_green, 8'h00);
        #1 flicker_phase = 1'b0;
        #1 chk("pf22_off_red", led_col_red, 8'h00);
        chk("pf22_off_green", led_col_green, 8'h00);
        flicker_phase = 1'b1;
        point_flicker_pos = 6'b111_111;
        do_tick(30, 1'b1);
        chk("pf77_r3_red", led_col_red, 8'h00);
        for (int k = 0; k < 4; k++) do_tick(30, 1'b1);
        chk("pf77_row", led_row, 8'h80);
        chk("pf77_red", led_col_red, 8'h80);
        chk("pf77_green", led_col_green, 8'h00);
        point_flicker_pos = 6'b000_111; point_flicker_color = 1'b1;
        do_tick(30, 1'b1);
        chk("pf07_green", led_col_green, 8'h80);
        chk("pf07_red", led_col_red, 8'h00);
        point_flicker_en = 1'b0;

        // Memory busy stall mid-fetch.
        en_off();
        mem[1] = 2'b01; mem[2] = 2'b10; mem[3] = 2'b10; mem[4] = 2'b01;
        mem[5] = 2'b01; mem[6] = 2'b10;
        for (int i = 8; i < 24; i++) mem[i] = 2'b11;
        en_on();
        repeat (5) @(posedge clk);
        #1 mem_busy = 1'b1;
        repeat (20) begin
            @(negedge clk);
            chk("busy_no_req", {7'd0, mem_en}, 8'h00);
        end
        @(posedge clk);
        #1 mem_busy = 1'b0;
        do_tick(30, 1'b1);
        chk("busy_r0_red", led_col_red, 8'b0100_1100);
        chk("busy_r0_green", led_col_green, 8'b0011_0010);

        // Screen and colour flicker.
        screen_flicker_en = 1'b1; flicker_phase = 1'b0;
        #1 chk("scr_red", led_col_red, 8'h00);
        chk("scr_green", led_col_green, 8'h00);
        flicker_phase = 1'b1;
        #1 chk("scr_on_red", led_col_red, 8'b0100_1100);
        screen_flicker_en = 1'b0;
        color_flicker_en = 1'b1; color_flicker_color = 1'b0; flicker_phase = 1'b0;
        #1 chk("cf_red_red", led_col_red, 8'h00);
        chk("cf_red_green", led_col_green, 8'b0011_0010);
        color_flicker_color = 1'b1;
        #1 chk("cf_green_red", led_col_red, 8'b0100_1100);
        chk("cf_green_green", led_col_green, 8'h00);
        color_flicker_en = 1'b0; flicker_phase = 1'b1;

        // Tick before the fetch completes.
        repeat (30) @(posedge clk);
        lat = 5;
        do_tick(0, 1'b1);
        chk("r1_red", led_col_red, 8'hFF);
        chk("r1_green", led_col_green, 8'hFF);
        do_tick(13, 1'b0);
        chk("part_row", led_row, 8'h04);
        chk("part_red", led_col_red, 8'h03);
        chk("part_green", led_col_green, 8'h03);
        lat = 1;
        do_tick(40, 1'b1);
        chk("r3_row", led_row, 8'h08);
        chk("r3_red", led_col_red, 8'h00);

        // Reset during a fetch.
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        #1 chk("mid_rst_row", led_row, 8'h00);
        chk("mid_rst_red", led_col_red, 8'h00);
        chk("mid_rst_green", led_col_green, 8'h00);
        chk("mid_rst_mem_en", {7'd0, mem_en}, 8'h00);
        exp_addr_q.delete();
        @(posedge clk);
        #1 en = 1'b0;
        rst = 1'b0;
        repeat (5) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
